// File: rtl/iob_down_counter_if.sv
// iob_down_counter_if: load handshake, control and status bundle for iob_down_counter
interface iob_down_counter_if #(
  parameter int DATA_W  = 32,
  parameter int PRESC_W = 8
);
  logic               en;
  logic [PRESC_W-1:0] presc;
  logic               load_valid;
  logic               load_ready;
  logic [DATA_W-1:0]  load_data;
  logic [DATA_W-1:0]  data_out;
  logic               busy;
  logic               done;
  modport master (
    output en, presc, load_valid, load_data,
    input  load_ready, data_out, busy, done
  );
  modport slave (
    input  en, presc, load_valid, load_data,
    output load_ready, data_out, busy, done
  );
endinterface

// File: rtl/iob_down_counter.sv
// iob_down_counter: loadable prescaled down-counter with one-cycle done pulse at terminal count
// Define IOB_DOWN_COUNTER_RELOAD_EN for periodic reload instead of one-shot operation.
module iob_down_counter #(
  parameter int DATA_W  = 32,
  parameter int PRESC_W = 8
) (
  input logic clk,
  input logic arst,
  input logic rst,
  iob_down_counter_if.slave bus
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t             state_q, state_d;
  logic [DATA_W-1:0]  cnt_q, cnt_d;
  logic [PRESC_W-1:0] pc_q, pc_d;
  logic               done_q, done_d;
  logic               tick, term;
`ifdef IOB_DOWN_COUNTER_RELOAD_EN
  logic [DATA_W-1:0]  rld_q, rld_d;
`endif
  assign tick = bus.en && pc_q == bus.presc;
  assign term = tick && cnt_q == DATA_W'(1);
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pc_d    = pc_q;
    done_d  = 1'b0;
`ifdef IOB_DOWN_COUNTER_RELOAD_EN
    rld_d   = rld_q;
`endif
    if (state_q == IDLE) begin
      if (bus.load_valid) begin
        cnt_d   = bus.load_data;
        pc_d    = '0;
        state_d = bus.load_data != '0 ? RUN : IDLE;
        done_d  = bus.load_data == '0;
`ifdef IOB_DOWN_COUNTER_RELOAD_EN
        rld_d   = bus.load_data;
`endif
      end
    end else if (bus.en) begin
      pc_d   = tick ? '0 : pc_q + 1'b1;
      done_d = term;
`ifdef IOB_DOWN_COUNTER_RELOAD_EN
      cnt_d  = term ? rld_q : tick ? cnt_q - 1'b1 : cnt_q;
`else
      cnt_d   = tick ? cnt_q - 1'b1 : cnt_q;
      state_d = term ? IDLE : RUN;
`endif
    end
    // synchronous clear overrides everything, including a pending load
    if (rst) begin
      state_d = IDLE;
      cnt_d   = '0;
      pc_d    = '0;
      done_d  = 1'b0;
`ifdef IOB_DOWN_COUNTER_RELOAD_EN
      rld_d   = '0;
`endif
    end
  end
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pc_q    <= '0;
      done_q  <= 1'b0;
`ifdef IOB_DOWN_COUNTER_RELOAD_EN
      rld_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
      done_q  <= done_d;
`ifdef IOB_DOWN_COUNTER_RELOAD_EN
      rld_q   <= rld_d;
`endif
    end
  end
  assign bus.load_ready = state_q == IDLE;
  assign bus.busy       = state_q == RUN;
  assign bus.data_out   = cnt_q;
  assign bus.done       = done_q;
endmodule

// File: tb/tb_iob_down_counter.sv
// tb_iob_down_counter: vector table, corner sequences and randomized model check of iob_down_counter
module tb_iob_down_counter;
  logic clk = 1'b0;
  logic arst, rst;
  int checks = 0;
  int errors = 0;
  iob_down_counter_if #(.DATA_W(32), .PRESC_W(8)) bus ();
  iob_down_counter #(.DATA_W(32), .PRESC_W(8)) dut (.clk(clk), .arst(arst), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    logic        r;
    logic        en;
    logic [7:0]  p;
    logic        lv;
    logic [31:0] ld;
    logic [31:0] dout;
    logic        busy;
    logic        rdy;
    logic        dn;
  } vec_t;
  vec_t vt [21];
  bit          m_act;
  int          m_n, m_p, m_k;
  logic [31:0] m_dout;
  logic        m_done;
  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, a, e);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic chk_all(input string nm, input logic [31:0] d, input logic b, input logic r, input logic dn);
    chk({nm, "_dout"}, bus.data_out, d);
    chk({nm, "_busy"}, 32'(bus.busy), 32'(b));
    chk({nm, "_ready"}, 32'(bus.load_ready), 32'(r));
    chk({nm, "_done"}, 32'(bus.done), 32'(dn));
  endtask
  task automatic do_rst();
    rst = 1'b1;
    bus.load_valid = 1'b0;
    cyc();
    rst = 1'b0;
  endtask
  task automatic model_step();
    int p1;
    m_done = 1'b0;
    if (rst) begin
      m_act  = 1'b0;
      m_dout = 0;
    end else if (m_act) begin
      if (bus.en) begin
        m_k++;
        p1 = m_p + 1;
`ifdef IOB_DOWN_COUNTER_RELOAD_EN
        m_done = (m_k % (m_n * p1)) == 0;
        m_dout = 32'(m_n - (m_k / p1) % m_n);
`else
        if (m_k == m_n * p1) begin
          m_act  = 1'b0;
          m_dout = 0;
          m_done = 1'b1;
        end else m_dout = 32'(m_n - m_k / p1);
`endif
      end
    end else if (bus.load_valid) begin
      if (bus.load_data == 0) begin
        m_dout = 0;
        m_done = 1'b1;
      end else begin
        m_act  = 1'b1;
        m_n    = int'(bus.load_data);
        m_p    = int'(bus.presc);
        m_k    = 0;
        m_dout = bus.load_data;
      end
    end
  endtask
  initial begin
    int n;
    arst = 1'b1;
    rst = 1'b0;
    bus.en = 1'b0;
    bus.presc = '0;
    bus.load_valid = 1'b0;
    bus.load_data = '0;
    #3;
    chk_all("reset", 0, 1'b0, 1'b1, 1'b0);
    #9 arst = 1'b0;
    // asynchronous reset in the middle of a count
    bus.load_valid = 1'b1;
    bus.load_data = 9;
    bus.en = 1'b1;
    cyc();
    bus.load_valid = 1'b0;
    cyc();
    cyc();
    chk("pre_arst_dout", bus.data_out, 7);
    #2 arst = 1'b1;
    #1;
    chk_all("arst", 0, 1'b0, 1'b1, 1'b0);
    #1 arst = 1'b0;
    // prescale 2, load 3, four disabled cycles mid-run
    bus.presc = 8'd2;
    bus.load_valid = 1'b1;
    bus.load_data = 3;
    bus.en = 1'b1;
    cyc();
    bus.load_valid = 1'b0;
    n = 0;
    for (int i = 0; i < 40 && !bus.done; i++) begin
      bus.en = !(n >= 3 && n <= 6);
      cyc();
      n++;
    end
    chk("gap_latency", 32'(n), 13);
`ifndef IOB_DOWN_COUNTER_RELOAD_EN
    chk("gap_busy", 32'(bus.busy), 0);
`endif
    bus.en = 1'b1;
    cyc();
    chk("gap_done_clear", 32'(bus.done), 0);
    do_rst();
`ifndef IOB_DOWN_COUNTER_RELOAD_EN
    vt[0]  = '{1, 0, 0, 0, 0, 0, 0, 1, 0};
    vt[1]  = '{0, 1, 0, 1, 5, 5, 1, 0, 0};
    vt[2]  = '{0, 1, 0, 0, 0, 4, 1, 0, 0};
    vt[3]  = '{0, 1, 0, 0, 0, 3, 1, 0, 0};
    vt[4]  = '{0, 1, 0, 0, 0, 2, 1, 0, 0};
    vt[5]  = '{0, 1, 0, 0, 0, 1, 1, 0, 0};
    vt[6]  = '{0, 1, 0, 0, 0, 0, 0, 1, 1};
    vt[7]  = '{0, 1, 0, 0, 0, 0, 0, 1, 0};
    vt[8]  = '{0, 0, 0, 1, 0, 0, 0, 1, 1};
    vt[9]  = '{0, 1, 0, 0, 0, 0, 0, 1, 0};
    vt[10] = '{0, 1, 0, 1, 2, 2, 1, 0, 0};
    vt[11] = '{0, 1, 0, 0, 0, 1, 1, 0, 0};
    vt[12] = '{0, 1, 0, 0, 0, 0, 0, 1, 1};
    vt[13] = '{0, 1, 0, 1, 2, 2, 1, 0, 0};
    vt[14] = '{0, 1, 0, 0, 0, 1, 1, 0, 0};
    vt[15] = '{0, 1, 0, 0, 0, 0, 0, 1, 1};
    vt[16] = '{0, 1, 0, 1, 6, 6, 1, 0, 0};
    vt[17] = '{0, 1, 0, 0, 0, 5, 1, 0, 0};
    vt[18] = '{0, 1, 0, 0, 0, 4, 1, 0, 0};
    vt[19] = '{1, 1, 0, 1, 9, 0, 0, 1, 0};
    vt[20] = '{0, 1, 0, 0, 0, 0, 0, 1, 0};
    for (int i = 0; i < 21; i++) begin
      rst = vt[i].r;
      bus.en = vt[i].en;
      bus.presc = vt[i].p;
      bus.load_valid = vt[i].lv;
      bus.load_data = vt[i].ld;
      cyc();
      chk_all($sformatf("vec%0d", i), vt[i].dout, vt[i].busy, vt[i].rdy, vt[i].dn);
    end
    rst = 1'b0;
    bus.load_valid = 1'b0;
`else
    // periodic reload: load 4 with presc 1 gives a done every 8 cycles
    bus.presc = 8'd1;
    bus.en = 1'b1;
    bus.load_valid = 1'b1;
    bus.load_data = 4;
    cyc();
    bus.load_valid = 1'b0;
    chk_all("rld_load", 4, 1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 24; k++) begin
      cyc();
      chk_all($sformatf("rld%0d", k), 32'(4 - (k / 2) % 4), 1'b1, 1'b0, 1'(k % 8 == 0));
    end
    do_rst();
`endif
    // randomized traffic against the behavioural model
    do_rst();
    m_act = 1'b0;
    m_dout = 0;
    m_done = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      rst = $urandom_range(0, 199) == 0;
      bus.en = $urandom_range(0, 3) != 0;
      bus.load_valid = $urandom_range(0, 3) == 0;
      bus.load_data = 32'($urandom_range(0, 6));
      if (!m_act) bus.presc = 8'($urandom_range(0, 3));
      cyc();
      model_step();
      chk_all($sformatf("rnd%0d", i), m_dout, m_act, !m_act, m_done);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
